// File: rtl/usb_fifo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : usb_fifo_sequencer
// Purpose  : FT245-style FIFO sequencer that arbitrates host byte reads
//            against tagged-nibble status reports with timed rd_n/wr_n strobes.
//            Optional transmit timeout: define USB_FIFO_SEQ_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module usb_fifo_sequencer #(
  parameter int STROBE_CYCLES   = 3,
  parameter int RECOVERY_CYCLES = 3,
  parameter int NUM_CHANNELS    = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rxf_n,
  input  logic                      txe_n,
  input  logic [7:0]                usb_data_in,
  input  logic                      report_request,
  input  logic [4*NUM_CHANNELS-1:0] report_data,
  output logic [7:0]                usb_data_out,
  output logic                      usb_data_oe,
  output logic                      rd_n,
  output logic                      wr_n,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  output logic                      report_done,
  output logic                      timeout_err,
  output logic                      busy,
  output logic [2:0]                state_out
);

  localparam int c_max_sr  = (STROBE_CYCLES > RECOVERY_CYCLES) ? STROBE_CYCLES : RECOVERY_CYCLES;
  localparam int c_max_cnt = (c_max_sr > TIMEOUT_CYCLES) ? c_max_sr : TIMEOUT_CYCLES;
  localparam int c_cnt_w   = $clog2(c_max_cnt + 1);

  localparam logic [c_cnt_w-1:0] c_strobe_last = c_cnt_w'(STROBE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_recov_last  = c_cnt_w'(RECOVERY_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
  localparam logic [3:0]         c_last_idx    = 4'(NUM_CHANNELS - 1);

  localparam logic [2:0] c_idle      = 3'd0;
  localparam logic [2:0] c_rd_strobe = 3'd1;
  localparam logic [2:0] c_rd_recov  = 3'd2;
  localparam logic [2:0] c_wr_wait   = 3'd3;
  localparam logic [2:0] c_wr_strobe = 3'd4;
  localparam logic [2:0] c_wr_recov  = 3'd5;
  localparam logic [2:0] c_done      = 3'd6;

  logic [2:0]                r_state;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [3:0]                r_idx;
  logic [4*NUM_CHANNELS-1:0] r_snap;
  logic [7:0]                r_rx_data;
  logic                      r_rx_valid;
  logic [3:0]                w_nibble;
  logic                      w_wr_phase;

`ifdef USB_FIFO_SEQ_TIMEOUT_EN
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  logic r_timeout_err;
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  // The shared counter is zeroed on every state change, so WR_WAIT entry
  // always starts the timeout count from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_idle;
      r_cnt      <= '0;
      r_idx      <= 4'd0;
      r_snap     <= '0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
`ifdef USB_FIFO_SEQ_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
`ifdef USB_FIFO_SEQ_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        c_idle: begin
          r_cnt <= '0;
          if (report_request) begin
            r_snap  <= report_data;
            r_idx   <= 4'd0;
            r_state <= c_wr_wait;
          end else if (!rxf_n) begin
            r_state <= c_rd_strobe;
          end
        end
        c_rd_strobe: begin
          if (r_cnt == c_strobe_last) begin
            r_rx_data  <= usb_data_in;
            r_rx_valid <= 1'b1;
            r_cnt      <= '0;
            r_state    <= c_rd_recov;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        c_rd_recov: begin
          if (r_cnt == c_recov_last) begin
            r_cnt   <= '0;
            r_state <= c_idle;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        c_wr_wait: begin
          if (!txe_n) begin
            r_cnt   <= '0;
            r_state <= c_wr_strobe;
          end
`ifdef USB_FIFO_SEQ_TIMEOUT_EN
          else if (r_cnt == c_timeout_last) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= c_idle;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
`endif
        end
        c_wr_strobe: begin
          if (r_cnt == c_strobe_last) begin
            r_cnt   <= '0;
            r_state <= c_wr_recov;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        c_wr_recov: begin
          if (r_cnt == c_recov_last) begin
            r_cnt <= '0;
            if (r_idx == c_last_idx) begin
              r_state <= c_done;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= c_wr_wait;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        c_done: begin
          r_cnt   <= '0;
          r_state <= c_idle;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= c_idle;
        end
      endcase
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (r_idx == 4'(i)) w_nibble = r_snap[4*i +: 4];
    end
  end

  // All outputs decode from registered state only; no input-to-output paths.
  assign w_wr_phase   = (r_state == c_wr_wait) || (r_state == c_wr_strobe) ||
                        (r_state == c_wr_recov) || (r_state == c_done);
  assign usb_data_oe  = w_wr_phase;
  assign usb_data_out = w_wr_phase ? {r_idx + 4'd1, w_nibble} : 8'h00;
  assign rd_n         = (r_state != c_rd_strobe);
  assign wr_n         = (r_state != c_wr_strobe);
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign report_done  = (r_state == c_done);
  assign busy         = (r_state != c_idle);
  assign state_out    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_usb_fifo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_fifo_sequencer
// Purpose  : Directed self-checking bench for usb_fifo_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_fifo_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        rxf_n;
  logic        txe_n;
  logic [7:0]  usb_data_in;
  logic        report_request;
  logic [15:0] report_data;
  logic [7:0]  usb_data_out;
  logic        usb_data_oe;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        report_done;
  logic        timeout_err;
  logic        busy;
  logic [2:0]  state_out;

  usb_fifo_sequencer #(
    .STROBE_CYCLES  (3),
    .RECOVERY_CYCLES(3),
    .NUM_CHANNELS   (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rxf_n         (rxf_n),
    .txe_n         (txe_n),
    .usb_data_in   (usb_data_in),
    .report_request(report_request),
    .report_data   (report_data),
    .usb_data_out  (usb_data_out),
    .usb_data_oe   (usb_data_oe),
    .rd_n          (rd_n),
    .wr_n          (wr_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .report_done   (report_done),
    .timeout_err   (timeout_err),
    .busy          (busy),
    .state_out     (state_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int cap_byte [8];
  int cap_len  [8];
  int nb, nl, done_cyc, done_cnt, rd_low, bp_bad;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issues a request at the current negedge and records the written bytes,
  // strobe lengths, report_done timing and any read strobes.
  task automatic run_report(input int max_cyc, input int chg_at, input int bp_at, input int bp_len);
    logic prev_wr;
    int   len;
    nb = 0; nl = 0; done_cyc = 0; done_cnt = 0; rd_low = 0; bp_bad = 0;
    len = 0; prev_wr = 1'b1;
    report_request = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 1) report_request = 1'b0;
      if (!rd_n) rd_low++;
      if (!wr_n) begin
        if (prev_wr && nb < 8) begin
          cap_byte[nb] = int'(usb_data_out);
          nb++;
        end
        len++;
      end else if (!prev_wr) begin
        if (nl < 8) cap_len[nl] = len;
        nl++;
        len = 0;
      end
      prev_wr = wr_n;
      if (cyc == chg_at) report_data = 16'hFFFF;
      if (bp_len > 0 && cyc > bp_at && cyc <= bp_at + bp_len) begin
        if (state_out !== 3'd3 || wr_n !== 1'b1 || usb_data_out !== 8'h33) bp_bad++;
      end
      if (bp_len > 0 && cyc == bp_at) txe_n = 1'b1;
      if (bp_len > 0 && cyc == bp_at + bp_len) txe_n = 1'b0;
      if (report_done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
        rxf_n = 1'b1;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 2) break;
    end
  endtask

  initial begin
    int rd_cnt, rv_cnt, to_cnt, to_cyc, dn_cnt;
    reset = 1'b1; rxf_n = 1'b1; txe_n = 1'b1; usb_data_in = 8'h00;
    report_request = 1'b0; report_data = 16'h0000;
    repeat (2) @(negedge clk);
    check_val("rst_state", 32'(state_out), 32'd0);
    check_val("rst_strobes", {30'd0, rd_n, wr_n}, 32'd3);
    check_val("rst_oe_data", {23'd0, usb_data_oe, usb_data_out}, 32'd0);
    check_val("rst_rx", {23'd0, rx_valid, rx_data}, 32'd0);
    check_val("rst_flags", {29'd0, report_done, timeout_err, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single byte read
    rxf_n = 1'b0; usb_data_in = 8'hA5;
    rd_cnt = 0; rv_cnt = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 1) rxf_n = 1'b1;
      if (!rd_n) rd_cnt++;
      if (rx_valid) rv_cnt++;
      if (cyc == 4) check_val("rd_valid_cyc4", {31'd0, rx_valid}, 32'd1);
      if (cyc == 6) check_val("rd_recov_cyc6", 32'(state_out), 32'd2);
      if (cyc == 7) check_val("rd_idle_cyc7", 32'(state_out), 32'd0);
    end
    check_val("rd_strobe_len", 32'(rd_cnt), 32'd3);
    check_val("rd_valid_cnt", 32'(rv_cnt), 32'd1);
    check_val("rd_data", 32'(rx_data), 32'hA5);

    // Plain report
    report_data = 16'h4321; txe_n = 1'b0;
    run_report(40, 0, 0, 0);
    check_val("rep_nbytes", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_val("rep_byte", 32'(cap_byte[i]), 32'(((i + 1) << 4) | (i + 1)));
      check_val("rep_wr_len", 32'(cap_len[i]), 32'd3);
    end
    check_val("rep_done_cyc", 32'(done_cyc), 32'd29);
    check_val("rep_done_cnt", 32'(done_cnt), 32'd1);
    check_val("rep_end_idle", 32'(state_out), 32'd0);

    // Priority over pending read, snapshot held while report_data changes
    report_data = 16'h9C5A; rxf_n = 1'b0;
    run_report(40, 10, 0, 0);
    check_val("pri_no_read", 32'(rd_low), 32'd0);
    check_val("snap_b0", 32'(cap_byte[0]), 32'h1A);
    check_val("snap_b1", 32'(cap_byte[1]), 32'h25);
    check_val("snap_b2", 32'(cap_byte[2]), 32'h3C);
    check_val("snap_b3", 32'(cap_byte[3]), 32'h49);
    check_val("pri_done_cyc", 32'(done_cyc), 32'd29);

    // Back-pressure before byte 3
    report_data = 16'h4321; rxf_n = 1'b1; txe_n = 1'b0;
    run_report(60, 0, 14, 10);
    check_val("bp_hold", 32'(bp_bad), 32'd0);
    check_val("bp_b2", 32'(cap_byte[2]), 32'h33);
    check_val("bp_b3", 32'(cap_byte[3]), 32'h44);
    check_val("bp_done_cyc", 32'(done_cyc), 32'd38);

    // Reset during WR_STROBE
    report_request = 1'b1; txe_n = 1'b0;
    @(posedge clk); @(negedge clk);
    report_request = 1'b0;
    @(posedge clk); @(negedge clk);
    check_val("mid_wr_low", {31'd0, wr_n}, 32'd0);
    reset = 1'b1;
    #1;
    check_val("mid_rst_wr", {31'd0, wr_n}, 32'd1);
    check_val("mid_rst_oe", {31'd0, usb_data_oe}, 32'd0);
    check_val("mid_rst_state", 32'(state_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dn_cnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (report_done) dn_cnt++;
    end
    check_val("mid_rst_nodone", 32'(dn_cnt), 32'd0);
    check_val("mid_rst_idle", 32'(state_out), 32'd0);

    // Transmit stall: timeout when enabled, indefinite wait otherwise
    txe_n = 1'b1; report_request = 1'b1;
    to_cnt = 0; to_cyc = 0; dn_cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (cyc == 1) report_request = 1'b0;
      if (timeout_err) begin
        to_cnt++;
        if (to_cyc == 0) to_cyc = cyc;
      end
      if (report_done) dn_cnt++;
    end
    check_val("stall_nodone", 32'(dn_cnt), 32'd0);
`ifdef USB_FIFO_SEQ_TIMEOUT_EN
    check_val("to_count", 32'(to_cnt), 32'd1);
    check_val("to_cycle", 32'(to_cyc), 32'd17);
    check_val("to_idle", 32'(state_out), 32'd0);
`else
    check_val("stall_no_to", 32'(to_cnt), 32'd0);
    check_val("stall_wait", 32'(state_out), 32'd3);
    check_val("stall_wr_high", {31'd0, wr_n}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_fifo_sequencer.md
# usb_fifo_sequencer

Parametrised next-generation sequencer for the FT245-style USB FIFO port. It arbitrates between host-to-FPGA byte reads and FPGA-to-host status reports, and generates `rd_n`/`wr_n` strobes with configurable pulse and recovery lengths. Each report is `NUM_CHANNELS` tagged nibble bytes taken from a snapshot of `report_data`. It sits between the FIFO pins and the command decoder/panel logic and adds captured receive data and an optional transmit timeout.

## Interface
- `STROBE_CYCLES`, default 3: cycles `rd_n`/`wr_n` are held low per byte; must be at least 1.
- `RECOVERY_CYCLES`, default 3: cycles strobe is high after each byte before the next action; must be at least 1.
- `NUM_CHANNELS`, default 4: nibbles per report, range 1..15.
- `TIMEOUT_CYCLES`, default 1024: `txe_n`-high cycles tolerated per byte; used only with `USB_FIFO_SEQ_TIMEOUT_EN`.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rxf_n`  in  1  FIFO has receive data when low.
- `txe_n`  in  1  FIFO can accept transmit data when low.
- `usb_data_in`  in  8  FIFO data bus, read direction.
- `report_request`  in  1  level request for a status report; sampled only in IDLE.
- `report_data`  in  4*NUM_CHANNELS  nibbles to report; nibble i is `[4i+3:4i]`.
- `usb_data_out`  out  8  FIFO data bus, write direction.
- `usb_data_oe`  out  1  bus driver enable.
- `rd_n`  out  1  FIFO read strobe.
- `wr_n`  out  1  FIFO write strobe.
- `rx_data`  out  8  last received byte, registered.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated.
- `report_done`  out  1  one-cycle pulse: report complete; requester clears its request.
- `timeout_err`  out  1  one-cycle pulse: report aborted on timeout.
- `busy`  out  1  state is not IDLE.
- `state_out`  out  3  current state encoding, for debug.

## Operation
- State encodings: IDLE=0, RD_STROBE=1, RD_RECOV=2, WR_WAIT=3, WR_STROBE=4, WR_RECOV=5, DONE=6. Codes 7 and above go to IDLE on the next edge.
- Outputs are decoded from registered state, counters and snapshot only; there are no input-to-output combinational paths.
- IDLE, request high: snapshot `report_data`, set `idx` to 0, go to WR_WAIT.
- IDLE, request low and `rxf_n` low: go to RD_STROBE.
- Report has priority over read when both are pending.
- RD_STROBE: `rd_n` low for `STROBE_CYCLES` cycles. The edge ending the last strobe cycle loads `rx_data` from `usb_data_in`, and `rx_valid` is high during the first RD_RECOV cycle.
- RD_RECOV: `rd_n` high for `RECOVERY_CYCLES` cycles, then IDLE.
- WR_WAIT, WR_STROBE, WR_RECOV and DONE all drive `usb_data_oe`=1 and `usb_data_out` = {idx+1 (4 bits), snapshot nibble idx}.
- WR_WAIT: leave for WR_STROBE on the first edge where `txe_n` is low. Minimum residency is 1 cycle, which guarantees data setup before `wr_n` falls.
- WR_STROBE: `wr_n` low for `STROBE_CYCLES` cycles.
- WR_RECOV: `wr_n` high for `RECOVERY_CYCLES` cycles. Then, if idx = NUM_CHANNELS-1, go to DONE; otherwise increment idx and go to WR_WAIT.
- DONE: one cycle with `report_done`=1, then IDLE. A request still high in IDLE starts a new report.
- `rd_n` and `wr_n` are never low simultaneously.
- `usb_data_oe` is 0 in IDLE, RD_STROBE and RD_RECOV.
- `report_data` changes during a report are ignored; the snapshot is held.
- `rxf_n` is ignored outside IDLE.

## Timing
- Reset values: state IDLE, `rd_n`=1, `wr_n`=1, `usb_data_oe`=0, `usb_data_out`=0, `rx_data`=0, `rx_valid`=0, `report_done`=0, `timeout_err`=0, `busy`=0, idx=0, counters 0.
- Reset asserted mid-operation immediately releases the strobes high and the bus driver.
- Read cycle: IDLE → IDLE takes 1 + `STROBE_CYCLES` + `RECOVERY_CYCLES` cycles (7 at defaults).
- Report length is `NUM_CHANNELS`*(1 + `STROBE_CYCLES` + `RECOVERY_CYCLES`) + 1 cycles with `txe_n` continuously low (29 at defaults).
- Strobe/recovery counter width is clog2(max(`STROBE_CYCLES`, `RECOVERY_CYCLES`, `TIMEOUT_CYCLES`) + 1).

## Configuration
- `USB_FIFO_SEQ_TIMEOUT_EN` defined:
  - A counter clears on each WR_WAIT entry and increments each WR_WAIT cycle with `txe_n` high.
  - On reaching `TIMEOUT_CYCLES`, go to IDLE, pulse `timeout_err` for one cycle, and do not assert `report_done`.
- `USB_FIFO_SEQ_TIMEOUT_EN` undefined:
  - The timeout counter is absent and `timeout_err` is tied 0.
  - WR_WAIT waits indefinitely.

## Test plan
- Read: defaults, `rxf_n` low, `usb_data_in`=8'hA5 → `rd_n` low for exactly 3 cycles; `rx_data`=8'hA5 with a 1-cycle `rx_valid`; IDLE 7 cycles after leaving IDLE.
- Report: `report_data`=16'h4321, `txe_n` low → bytes 8'h11, 8'h22, 8'h33, 8'h44, each with a 3-cycle `wr_n` low; `report_done` pulses once at cycle 29.
- Priority and snapshot: `report_request` and `rxf_n` asserted in the same cycle → write starts, no `rd_n` activity. Changing `report_data` mid-report leaves the transmitted bytes unchanged.
- Back-pressure: `txe_n` high for 10 cycles before byte 3 → state holds at 3, `wr_n` stays high, `usb_data_out`=8'h33 stable; resumes when `txe_n` goes low.
- Reset mid-strobe: `reset` asserted during WR_STROBE → `wr_n`=1, `usb_data_oe`=0 and `state_out`=0 immediately; no `report_done`.
- Timeout (macro defined, `TIMEOUT_CYCLES`=16): `txe_n` held high → one `timeout_err` pulse after 16 WR_WAIT cycles, return to IDLE, no `report_done`. With the macro undefined, the design stays in WR_WAIT.
